mem_cmd_queue: RTL and testbench
================================

Name: mem_cmd_queue

Overview:
- Parametrised request buffer between the core-side memory port and the cache controller.
- Each accepted memory command (M_* encoding, 5-bit) is decoded once at enqueue into class flags: read, write, AMO, prefetch and write-intent.
- Flags are stored with the entry, so downstream logic needs no re-decode.
- Also drops prefetches under pressure, rejects undefined commands, and optionally treats M_FLUSH_ALL/M_SFENCE as an ingress barrier.

Parameters:
- DEPTH, 4, number of entries; power of two, >=2.
- ADDR_W, 40, request address width.
- DATA_W, 64, store/AMO operand width.
- TAG_W, 8, request tag width.
- PF_DROP_THRESH, 1, prefetch is dropped when free slots (before enqueue) <= this value; 0 disables dropping.
- BARRIER_EN, 1, 1 = M_FLUSH_ALL/M_SFENCE block ingress while resident in the queue.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_cmd  in  5  M_* command.
- req_addr  in  ADDR_W  address.
- req_data  in  DATA_W  operand.
- req_tag  in  TAG_W  tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head when valid&ready.
- out_cmd  out  5  head command.
- out_addr  out  ADDR_W  head address.
- out_data  out  DATA_W  head operand.
- out_tag  out  TAG_W  head tag.
- out_is_read, out_is_write, out_is_amo, out_is_prefetch, out_is_write_intent  out  1 each  stored class flags.
- count  out  $clog2(DEPTH+1)  occupied entries.
- pf_dropped  out  1  one-cycle pulse, a prefetch was accepted but discarded.
- illegal_cmd  out  1  one-cycle pulse, an undefined command was accepted and discarded.
- illegal_tag  out  TAG_W  tag of the last illegal command; holds until the next one.

Behaviour:
- Clock and reset: single clock domain, synchronous active-high reset.
- Reset values: pointers=0, count=0, out_valid=0, pf_dropped=0, illegal_cmd=0, illegal_tag=0, barrier flag=0.
- Reset mid-operation: all entries are discarded and none are emitted after reset.
- Handshake rules:
  - req_ready = (count<DEPTH) && !(BARRIER_EN && barrier_resident).
  - req_ready never depends on req_valid or req_cmd.
  - out_valid = (count>0).
  - out_* fields are undefined when out_valid=0.
- Latency: an accepted entry appears at the head no earlier than the next cycle; there is no fall-through path. With an empty queue it appears at exactly the next cycle.
- Decode:
  - amo = cmd in {00100, 01000..01111}.
  - prefetch = cmd in {00010, 00011}.
  - read = XRD(00000) | XLR(00110) | XSC(00111) | amo.
  - write = XWR(00001) | PWR(10001) | XSC | amo.
  - write_intent = write | PFW(00011) | XLR.
  - Legal set: 00000..10100 and 10111. Everything else is illegal: 10101, 10110, 11000..11111.
- Accept outcomes: on accept, exactly one of the following happens.
  - Illegal cmd: not enqueued. Next cycle illegal_cmd=1 and illegal_tag=req_tag.
  - Prefetch with PF_DROP_THRESH>0 and (DEPTH-count)<=PF_DROP_THRESH: not enqueued. Next cycle pf_dropped=1.
  - Otherwise: written at tail; tail increments modulo DEPTH.
- Pointers wrap modulo DEPTH; full and empty are distinguished by count.
- Simultaneous enqueue and dequeue in one cycle: count is unchanged; a single-entry queue stays valid with the new entry.
- Dequeue of a full queue opens req_ready on the following cycle only, because ready is computed from the registered count.
- Barrier (BARRIER_EN=1):
  - barrier_resident is set when M_FLUSH_ALL(00101) or M_SFENCE(10100) is enqueued.
  - It clears in the cycle the barrier entry is dequeued, so req_ready can be high the next cycle.
  - At most one barrier is resident.
  - Entries enqueued before the barrier drain normally, in order.
- Ordering: strict FIFO for all enqueued entries.

Test Plan:
- Ordering and latency: reset, then enqueue XRD tag1, XWR tag2, XA_ADD tag3 back-to-back, with out_ready=1 from cycle 4 -> heads in order 1,2,3. Flags: tag1 read; tag2 write; tag3 read+write+amo+write_intent. count peaks at 3.
- Full, wrap and simultaneous traffic: DEPTH=4, PF_DROP_THRESH=0, fill with 4 XRD -> req_ready=0 and count=4. Pop one -> ready=1 the next cycle. Then run 10 cycles of simultaneous enqueue/dequeue -> count stays 3 and tags emerge in order across the pointer wrap.
- Prefetch drop: THRESH=1, fill to 3, then send PFR tag9 -> accepted, pf_dropped pulses one cycle, count stays 3. A PFW sent at count=1 is enqueued with prefetch=1 and write_intent=1.
- Illegal command: send cmd 10110 tag 0x5A -> accepted, illegal_cmd=1 for one cycle, illegal_tag=0x5A, count unchanged. cmd 10111 (WOK) is enqueued with all flags 0.
- Barrier: enqueue XRD, then FLUSH_ALL -> req_ready=0 until FLUSH_ALL leaves the head. With BARRIER_EN=0 the same stimulus never deasserts req_ready (count<DEPTH).
- Reset mid-operation: with count=3, assert reset for 1 cycle -> out_valid=0, count=0, pulses 0. Next enqueue appears at the head after 1 cycle.

Source files
------------

// File: rtl/mem_cmd_queue.sv
// mem_cmd_queue: FIFO of memory commands, decoded into class flags at enqueue,
// with prefetch dropping under pressure, illegal-command rejection and an ingress barrier.
module mem_cmd_queue #(
   parameter int DEPTH          = 4,
   parameter int ADDR_W         = 40,
   parameter int DATA_W         = 64,
   parameter int TAG_W          = 8,
   parameter int PF_DROP_THRESH = 1,
   parameter int BARRIER_EN     = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [4:0]                   req_cmd,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_data,
   input  logic [TAG_W-1:0]             req_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [4:0]                   out_cmd,
   output logic [ADDR_W-1:0]            out_addr,
   output logic [DATA_W-1:0]            out_data,
   output logic [TAG_W-1:0]             out_tag,
   output logic                         out_is_read,
   output logic                         out_is_write,
   output logic                         out_is_amo,
   output logic                         out_is_prefetch,
   output logic                         out_is_write_intent,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         pf_dropped,
   output logic                         illegal_cmd,
   output logic [TAG_W-1:0]             illegal_tag
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [4:0]        cmd_q  [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [4:0]        flg_q  [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     cnt_q, cnt_d, free;
   logic              bar_q, bar_d, pf_q, pf_d, ill_q, ill_d;
   logic [TAG_W-1:0]  itag_q, itag_d;
   logic              acc, enq, deq, drop, head_bar;
   logic              is_amo, is_pf, is_rd, is_wr, is_wi, is_ill, is_bar;

   always_comb begin
      is_amo    = req_cmd == 5'b00100 || req_cmd[4:3] == 2'b01;
      is_pf     = req_cmd[4:1] == 4'b0001;
      is_rd     = req_cmd == 5'b00000 || req_cmd[4:1] == 4'b0011 || is_amo;
      is_wr     = req_cmd == 5'b00001 || req_cmd == 5'b10001 || req_cmd == 5'b00111 || is_amo;
      is_wi     = is_wr || req_cmd == 5'b00011 || req_cmd == 5'b00110;
      is_ill    = req_cmd == 5'b10101 || req_cmd == 5'b10110 || req_cmd[4:3] == 2'b11;
      is_bar    = req_cmd == 5'b00101 || req_cmd == 5'b10100;
      free      = CW'(DEPTH) - cnt_q;
      drop      = is_pf && PF_DROP_THRESH > 0 && int'(free) <= PF_DROP_THRESH;
      // ready comes from registered state only, so a pop never opens ingress in the same cycle
      req_ready = cnt_q < CW'(DEPTH) && !(BARRIER_EN != 0 && bar_q);
      out_valid = cnt_q != '0;
      acc       = req_valid && req_ready;
      enq       = acc && !is_ill && !drop;
      deq       = out_valid && out_ready;
      head_bar  = out_cmd == 5'b00101 || out_cmd == 5'b10100;
      head_d    = deq ? head_q + PW'(1) : head_q;
      tail_d    = enq ? tail_q + PW'(1) : tail_q;
      cnt_d     = cnt_q + CW'(enq) - CW'(deq);
      bar_d     = BARRIER_EN != 0 && (enq && is_bar ? 1'b1 : deq && head_bar ? 1'b0 : bar_q);
      pf_d      = acc && drop;
      ill_d     = acc && is_ill;
      itag_d    = acc && is_ill ? req_tag : itag_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         bar_q  <= 1'b0;
         pf_q   <= 1'b0;
         ill_q  <= 1'b0;
         itag_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         bar_q  <= bar_d;
         pf_q   <= pf_d;
         ill_q  <= ill_d;
         itag_q <= itag_d;
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         cmd_q[tail_q]  <= req_cmd;
         addr_q[tail_q] <= req_addr;
         data_q[tail_q] <= req_data;
         tag_q[tail_q]  <= req_tag;
         flg_q[tail_q]  <= {is_rd, is_wr, is_amo, is_pf, is_wi};
      end
   end

   assign out_cmd  = cmd_q[head_q];
   assign out_addr = addr_q[head_q];
   assign out_data = data_q[head_q];
   assign out_tag  = tag_q[head_q];
   assign {out_is_read, out_is_write, out_is_amo, out_is_prefetch, out_is_write_intent} = flg_q[head_q];
   assign count       = cnt_q;
   assign pf_dropped  = pf_q;
   assign illegal_cmd = ill_q;
   assign illegal_tag = itag_q;
endmodule

// File: tb/tb_mem_cmd_queue.sv
// tb_mem_cmd_queue: directed and random stimulus checked against a queue-based model.
module tb_mem_cmd_queue;
   localparam logic [4:0] XRD = 5'b00000, XWR = 5'b00001, PFR = 5'b00010, PFW = 5'b00011;
   localparam logic [4:0] XADD = 5'b01000, FLUSH = 5'b00101, SFENCE = 5'b10100;
   localparam int THRESH = 1;

   typedef struct {
      logic [4:0]  cmd;
      logic [39:0] addr;
      logic [63:0] data;
      logic [7:0]  tag;
   } ent_t;

   logic        clock = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, out_ready = 1'b0;
   logic [4:0]  req_cmd = '0;
   logic [39:0] req_addr = '0;
   logic [63:0] req_data = '0;
   logic [7:0]  req_tag = '0;
   logic        req_ready, out_valid, pf_dropped, illegal_cmd;
   logic        o_rd, o_wr, o_amo, o_pf, o_wi;
   logic [4:0]  out_cmd;
   logic [39:0] out_addr;
   logic [63:0] out_data;
   logic [7:0]  out_tag, illegal_tag;
   logic [2:0]  count;

   logic        nb_valid = 1'b0, nb_oready = 1'b0, nb_ready, nb_ovalid, nb_pf, nb_ill;
   logic [4:0]  nb_cmd = '0, nb_ocmd, nb_flags;
   logic [39:0] nb_oaddr;
   logic [63:0] nb_odata;
   logic [7:0]  nb_otag, nb_itag;
   logic [2:0]  nb_count;

   int total = 0, bad = 0;
   ent_t q[$];
   bit   ep = 0, ei = 0;
   logic [7:0] eit = '0;

   always #5 clock = ~clock;

   mem_cmd_queue u_dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .out_addr(out_addr),
      .out_data(out_data), .out_tag(out_tag), .out_is_read(o_rd), .out_is_write(o_wr),
      .out_is_amo(o_amo), .out_is_prefetch(o_pf), .out_is_write_intent(o_wi),
      .count(count), .pf_dropped(pf_dropped), .illegal_cmd(illegal_cmd), .illegal_tag(illegal_tag)
   );

   mem_cmd_queue #(.PF_DROP_THRESH(0), .BARRIER_EN(0)) u_nb (
      .clock(clock), .reset(reset), .req_valid(nb_valid), .req_ready(nb_ready),
      .req_cmd(nb_cmd), .req_addr(40'h0), .req_data(64'h0), .req_tag(8'h0),
      .out_valid(nb_ovalid), .out_ready(nb_oready), .out_cmd(nb_ocmd), .out_addr(nb_oaddr),
      .out_data(nb_odata), .out_tag(nb_otag), .out_is_read(nb_flags[4]), .out_is_write(nb_flags[3]),
      .out_is_amo(nb_flags[2]), .out_is_prefetch(nb_flags[1]), .out_is_write_intent(nb_flags[0]),
      .count(nb_count), .pf_dropped(nb_pf), .illegal_cmd(nb_ill), .illegal_tag(nb_itag)
   );

   function automatic logic [4:0] flags(input logic [4:0] c);
      logic amo, pf, rd, wr, wi;
      amo = c inside {5'b00100, [5'b01000:5'b01111]};
      pf  = c inside {5'b00010, 5'b00011};
      rd  = c inside {5'b00000, 5'b00110, 5'b00111} || amo;
      wr  = c inside {5'b00001, 5'b10001, 5'b00111} || amo;
      wi  = wr || c inside {5'b00011, 5'b00110};
      return {rd, wr, amo, pf, wi};
   endfunction

   function automatic bit m_ready();
      foreach (q[i]) if (q[i].cmd inside {FLUSH, SFENCE}) return 0;
      return q.size() < 4;
   endfunction

   task automatic chk(input string tg, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tg, o, e);
      end
   endtask

   task automatic check_all();
      chk("req_ready", req_ready, m_ready());
      chk("out_valid", out_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("pf_dropped", pf_dropped, ep);
      chk("illegal_cmd", illegal_cmd, ei);
      chk("illegal_tag", illegal_tag, eit);
      if (q.size() != 0) begin
         chk("out_cmd", out_cmd, q[0].cmd);
         chk("out_addr", out_addr, q[0].addr);
         chk("out_data", out_data, q[0].data);
         chk("out_tag", out_tag, q[0].tag);
         chk("out_flags", {o_rd, o_wr, o_amo, o_pf, o_wi}, flags(q[0].cmd));
      end
   endtask

   task automatic cyc(input bit v, input logic [4:0] c, input logic [7:0] t, input bit ordy);
      ent_t e;
      bit acc, deq, ill, drop;
      e.cmd = c; e.tag = t;
      e.addr = 40'({$urandom(), $urandom()});
      e.data = {$urandom(), $urandom()};
      req_valid = v; req_cmd = c; req_tag = t; req_addr = e.addr; req_data = e.data; out_ready = ordy;
      acc  = v && m_ready();
      deq  = ordy && q.size() != 0;
      ill  = c inside {5'b10101, 5'b10110, [5'b11000:5'b11111]};
      drop = c inside {PFR, PFW} && THRESH > 0 && (4 - q.size()) <= THRESH;
      @(posedge clock);
      ep = 0; ei = 0;
      if (deq) void'(q.pop_front());
      if (acc) begin
         if (ill) begin ei = 1; eit = t; end
         else if (drop) ep = 1;
         else q.push_back(e);
      end
      @(negedge clock);
      req_valid = 0;
      check_all();
   endtask

   task automatic do_reset();
      req_valid = 0; out_ready = 0; reset = 1;
      @(posedge clock);
      q.delete(); ep = 0; ei = 0; eit = '0;
      @(negedge clock);
      reset = 0;
      check_all();
   endtask

   initial begin
      @(negedge clock);
      do_reset();
      // barrier disabled: ingress stays open while a flush is resident
      nb_valid = 1; nb_cmd = XRD;
      @(negedge clock); chk("nb_ready1", nb_ready, 1); chk("nb_count1", nb_count, 1);
      nb_cmd = FLUSH;
      @(negedge clock); chk("nb_ready2", nb_ready, 1); chk("nb_count2", nb_count, 2);
      nb_cmd = XRD;
      @(negedge clock); chk("nb_ready3", nb_ready, 1); chk("nb_count3", nb_count, 3);
      nb_valid = 0; nb_oready = 1;
      @(negedge clock); chk("nb_head", nb_ocmd, FLUSH); chk("nb_count4", nb_count, 2);
      @(negedge clock); chk("nb_ready4", nb_ready, 1); chk("nb_head2", nb_ocmd, XRD);
      check_all();
      // ordering and latency
      cyc(1, XRD, 1, 0); cyc(1, XWR, 2, 0); cyc(1, XADD, 3, 0);
      repeat (4) cyc(0, XRD, 0, 1);
      // full, pop, then simultaneous traffic across the wrap
      for (int i = 0; i < 4; i++) cyc(1, XRD, 8'(10 + i), 0);
      cyc(1, XRD, 14, 0);
      cyc(0, XRD, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, XRD, 8'(20 + i), 1);
      repeat (4) cyc(0, XRD, 0, 1);
      // prefetch drop near full, prefetch kept when roomy
      for (int i = 0; i < 3; i++) cyc(1, XRD, 8'(40 + i), 0);
      cyc(1, PFR, 9, 0);
      cyc(0, XRD, 0, 0);
      repeat (3) cyc(0, XRD, 0, 1);
      cyc(1, XRD, 50, 0); cyc(1, PFW, 51, 0);
      repeat (3) cyc(0, XRD, 0, 1);
      // illegal and the WOK edge of the legal set
      cyc(1, 5'b10110, 8'h5A, 0); cyc(1, 5'b10111, 60, 0); cyc(1, 5'b10101, 61, 0);
      repeat (2) cyc(0, XRD, 0, 1);
      // barrier blocks ingress until it leaves the head
      cyc(1, XRD, 70, 0); cyc(1, FLUSH, 71, 0); cyc(1, XRD, 72, 0);
      cyc(1, XRD, 73, 1); cyc(1, XRD, 74, 1); cyc(1, SFENCE, 75, 1);
      repeat (3) cyc(0, XRD, 0, 1);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 8'($urandom), $urandom_range(0, 1) == 1);
      // reset mid-operation
      repeat (5) cyc(0, XRD, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, XWR, 8'(80 + i), 0);
      do_reset();
      cyc(1, XRD, 90, 0);
      cyc(0, XRD, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
